cell_truth_sweeper: RTL and testbench

Sequential stimulus/check stage placed directly upstream of a single standard-cell instance (INV1, NAND2, AOI21, XOR3, MUX2, etc.) in the TIGFET cell-library regression bench. On `start`, the block steps the cell's inputs through every vector, waits a fixed settle time, and samples the cell output `Y`. It compares each sample against an expected truth table and reports the mismatch count, the first failing vector, and an overall pass/fail. One instance serves any cell with up to 4 inputs, because the expected truth table is a port and not a parameter.

---
 rtl/cell_sweep_pkg.sv | 15 +
 rtl/cell_truth_sweeper.sv | 167 ++++++++++++++++
 tb/tb_cell_truth_sweeper.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/cell_sweep_pkg.sv
// Shared types and widths for the cell truth-table sweeper.
package cell_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } sweep_state_t;

  localparam int MAX_IN = 4;
  localparam int TT_W   = 16;
  localparam int ERR_W  = 5;

endpackage

// File: rtl/cell_truth_sweeper.sv
// Steps a standard cell through every input vector and checks Y against a truth table.
// Optional build macro: SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module cell_truth_sweeper
  import cell_sweep_pkg::*;
#(
  parameter int N_IN   = 3,
  parameter int SETTLE = 2
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             start,
  input  logic [TT_W-1:0]  exp_tt,
  output logic [N_IN-1:0]  stim,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam logic [3:0]       RELOAD   = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0]  LAST_VEC = '1;
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(TT_W);

  sweep_state_t     state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic [TT_W-1:0]  tt_q, tt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       ffv_q, ffv_d;
  logic             ffvalid_q, ffvalid_d;

  logic             accept_s;
  logic             mismatch_s;
  logic             finish_s;
  logic [3:0]       vec_idx_s;
  logic [ERR_W-1:0] err_next_s;

  assign vec_idx_s  = 4'(stim_q);
  assign accept_s   = start && ((state_q == IDLE) || (state_q == DONE));
  assign mismatch_s = (state_q == SAMPLE) && (dut_y != tt_q[vec_idx_s]);
  assign err_next_s = (mismatch_s && (err_q < ERR_MAX)) ? (err_q + 5'd1) : err_q;

`ifdef SWEEP_STOP_ON_FAIL_EN
  assign finish_s = (stim_q == LAST_VEC) || mismatch_s;
`else
  assign finish_s = (stim_q == LAST_VEC);
`endif

  // State and datapath registers
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      stim_q    <= '0;
      tt_q      <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= 5'd0;
      ffv_q     <= 4'd0;
      ffvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stim_q    <= stim_d;
      tt_q      <= tt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = DRIVE;
        else       state_d = IDLE;
      end
      DRIVE: begin
        if (cnt_q == 4'd0) state_d = SAMPLE;
        else               state_d = DRIVE;
      end
      SAMPLE: begin
        if (finish_s) state_d = DONE;
        else          state_d = DRIVE;
      end
      DONE: begin
        if (start) state_d = DRIVE;
        else       state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered-output and counter updates
  always_comb begin
    cnt_d     = cnt_q;
    stim_d    = stim_q;
    tt_d      = tt_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    if (accept_s) begin
      tt_d      = exp_tt;
      stim_d    = '0;
      cnt_d     = RELOAD;
      err_d     = 5'd0;
      ffv_d     = 4'd0;
      ffvalid_d = 1'b0;
      done_d    = 1'b0;
      pass_d    = 1'b0;
      busy_d    = 1'b1;
    end else begin
      case (state_q)
        DRIVE: begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else               cnt_d = cnt_q;
        end
        SAMPLE: begin
          err_d = err_next_s;
          if (mismatch_s && !ffvalid_q) begin
            ffv_d     = vec_idx_s;
            ffvalid_d = 1'b1;
          end else begin
            ffv_d     = ffv_q;
            ffvalid_d = ffvalid_q;
          end
          // The last vector's error is already folded into err_next_s here.
          if (finish_s) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_next_s == 5'd0);
          end else begin
            stim_d = stim_q + 1'b1;
            cnt_d  = RELOAD;
          end
        end
        default: begin
          cnt_d = cnt_q;
        end
      endcase
    end
  end

  assign stim             = stim_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_cnt          = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_cell_truth_sweeper.sv
// Directed bench: NAND2, XOR3 and 4-input tied-low cells behind three sweeper instances.
module tb_cell_truth_sweeper;

  logic        CK = 1'b0;
  logic        RN = 1'b0;

  logic        st2 = 1'b0, st3 = 1'b0, st4 = 1'b0;
  logic [15:0] tt2 = 16'd0, tt3 = 16'd0, tt4 = 16'd0;
  logic [1:0]  s2;
  logic [2:0]  s3;
  logic [3:0]  s4;
  logic        y2, y3, y4;
  logic        b2, b3, b4, d2, d3, d4, p2, p3, p4;
  logic [4:0]  e2, e3, e4;
  logic [3:0]  fv2, fv3, fv4;
  logic        fok2, fok3, fok4;

  logic        y2_zero = 1'b0;
  logic        f3_en   = 1'b0;
  logic [2:0]  f3_vec  = 3'd0;

  int vectors = 0;
  int miscompares = 0;
  int edges;

  always #5 CK = ~CK;

  assign y2 = y2_zero ? 1'b0 : ~(s2[0] & s2[1]);
  assign y3 = (^s3) ^ (f3_en && (s3 == f3_vec));
  assign y4 = 1'b0;

  cell_truth_sweeper #(.N_IN(2), .SETTLE(2)) u2 (
    .CK(CK), .RN(RN), .start(st2), .exp_tt(tt2), .stim(s2), .dut_y(y2),
    .busy(b2), .done(d2), .pass(p2), .err_cnt(e2),
    .first_fail_vec(fv2), .first_fail_valid(fok2));

  cell_truth_sweeper #(.N_IN(3), .SETTLE(2)) u3 (
    .CK(CK), .RN(RN), .start(st3), .exp_tt(tt3), .stim(s3), .dut_y(y3),
    .busy(b3), .done(d3), .pass(p3), .err_cnt(e3),
    .first_fail_vec(fv3), .first_fail_valid(fok3));

  cell_truth_sweeper #(.N_IN(4), .SETTLE(1)) u4 (
    .CK(CK), .RN(RN), .start(st4), .exp_tt(tt4), .stim(s4), .dut_y(y4),
    .busy(b4), .done(d4), .pass(p4), .err_cnt(e4),
    .first_fail_vec(fv4), .first_fail_valid(fok4));

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int which);
    case (which)
      2:       return d2;
      3:       return d3;
      default: return d4;
    endcase
  endfunction

  task automatic set_start(input int which, input logic v);
    case (which)
      2:       st2 = v;
      3:       st3 = v;
      default: st4 = v;
    endcase
  endtask

  // Drive one start pulse; returns just after the accept edge.
  task automatic start_sweep(input int which, input logic [15:0] tt);
    case (which)
      2:       tt2 = tt;
      3:       tt3 = tt;
      default: tt4 = tt;
    endcase
    set_start(which, 1'b1);
    tick();
    set_start(which, 1'b0);
  endtask

  task automatic wait_done(input int which, input int base, input int limit, output int n);
    n = base;
    while (!done_of(which) && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    // Reset state
    tick();
    chk("rst_stim", 32'(s3), 32'd0);
    chk("rst_busy", 32'(b3), 32'd0);
    chk("rst_done", 32'(d2), 32'd0);
    chk("rst_pass", 32'(p4), 32'd0);
    chk("rst_err",  32'(e4), 32'd0);
    chk("rst_ffok", 32'(fok2), 32'd0);
    RN = 1'b1;
    tick();

    // NAND2 reference
    start_sweep(2, 16'h0007);
    chk("nand_busy", 32'(b2), 32'd1);
    wait_done(2, 0, 60, edges);
    chk("nand_edges", 32'(edges), 32'd12);
    chk("nand_pass",  32'(p2), 32'd1);
    chk("nand_err",   32'(e2), 32'd0);
    chk("nand_ffok",  32'(fok2), 32'd0);
    chk("nand_busy0", 32'(b2), 32'd0);
    chk("nand_stim",  32'(s2), 32'd3);

    // NAND2 truth table against an output stuck at 0
    y2_zero = 1'b1;
    start_sweep(2, 16'h0007);
    wait_done(2, 0, 60, edges);
`ifdef SWEEP_STOP_ON_FAIL_EN
    chk("z_edges", 32'(edges), 32'd3);
    chk("z_err",   32'(e2), 32'd1);
    chk("z_stim",  32'(s2), 32'd0);
`else
    chk("z_edges", 32'(edges), 32'd12);
    chk("z_err",   32'(e2), 32'd3);
`endif
    chk("z_ffv",  32'(fv2), 32'd0);
    chk("z_ffok", 32'(fok2), 32'd1);
    chk("z_pass", 32'(p2), 32'd0);

    // XOR3 with vector 5 forced wrong
    f3_en = 1'b1;
    f3_vec = 3'd5;
    start_sweep(3, 16'h0096);
    wait_done(3, 0, 100, edges);
`ifdef SWEEP_STOP_ON_FAIL_EN
    chk("x5_edges", 32'(edges), 32'd18);
    chk("x5_stim",  32'(s3), 32'd5);
`else
    chk("x5_edges", 32'(edges), 32'd24);
    chk("x5_stim",  32'(s3), 32'd7);
`endif
    chk("x5_err",  32'(e3), 32'd1);
    chk("x5_ffv",  32'(fv3), 32'd5);
    chk("x5_pass", 32'(p3), 32'd0);

    // Clean XOR3 with a second start pulse at cycle 5, ignored
    f3_en = 1'b0;
    start_sweep(3, 16'h0096);
    for (int i = 0; i < 4; i++) tick();
    st3 = 1'b1;
    tick();
    st3 = 1'b0;
    chk("rs_busy", 32'(b3), 32'd1);
    wait_done(3, 5, 100, edges);
    chk("rs_edges", 32'(edges), 32'd24);
    chk("rs_pass",  32'(p3), 32'd1);
    chk("rs_err",   32'(e3), 32'd0);
    chk("rs_ffok",  32'(fok3), 32'd0);

    // Reset during SAMPLE of vector 4
    start_sweep(3, 16'h0096);
    for (int i = 0; i < 14; i++) tick();
    chk("ab_stim_pre", 32'(s3), 32'd4);
    RN = 1'b0;
    #1;
    chk("ab_stim", 32'(s3), 32'd0);
    chk("ab_busy", 32'(b3), 32'd0);
    chk("ab_done", 32'(d2), 32'd0);
    chk("ab_err",  32'(e2), 32'd0);
    chk("ab_ffok", 32'(fok2), 32'd0);
    tick();
    RN = 1'b1;
    tick();
    start_sweep(3, 16'h0096);
    wait_done(3, 0, 100, edges);
    chk("ab_edges", 32'(edges), 32'd24);
    chk("ab_pass",  32'(p3), 32'd1);
    chk("ab_err2",  32'(e3), 32'd0);

    // 4 inputs, SETTLE=1, all-ones table against a stuck-at-0 output
    start_sweep(4, 16'hFFFF);
    wait_done(4, 0, 100, edges);
`ifdef SWEEP_STOP_ON_FAIL_EN
    chk("w_edges", 32'(edges), 32'd2);
    chk("w_err",   32'(e4), 32'd1);
    chk("w_stim",  32'(s4), 32'd0);
`else
    chk("w_edges", 32'(edges), 32'd32);
    chk("w_err",   32'(e4), 32'd16);
    chk("w_stim",  32'(s4), 32'd15);
`endif
    chk("w_ffv",  32'(fv4), 32'd0);
    chk("w_pass", 32'(p4), 32'd0);

    // Start held high in DONE restarts immediately
    st4 = 1'b1;
    tick();
    chk("hold_busy", 32'(b4), 32'd1);
    chk("hold_done", 32'(d4), 32'd0);
    st4 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
